// File: rtl/tdc_pkg.sv
// tdc_pkg: widths and defaults shared by the TDC core, the statistics stage and the top level.
package tdc_pkg;
   localparam int TDC_MEAS_W = 40;
   localparam int TDC_LOG2_N = 4;
   localparam int TDC_ACC_W  = TDC_MEAS_W + TDC_LOG2_N;

   // Sized so that a full window of all-ones samples cannot overflow.
   function automatic int acc_w(input int meas_w, input int log2_n);
      return meas_w + log2_n;
   endfunction
endpackage

// File: rtl/tdc_minmax_track.sv
// tdc_minmax_track: running unsigned min/max of a sample stream.
// The next values are exposed so the parent can capture a window result that includes the current sample.
module tdc_minmax_track import tdc_pkg::*; #(
   parameter int W = TDC_MEAS_W
) (
   input  logic         clk_100m,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_upd,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_min_nxt,
   output logic [W-1:0] o_max_nxt
);
   logic [W-1:0] r_min, r_max;

   always_comb begin
      o_min_nxt = i_load ? i_d : (i_d < r_min ? i_d : r_min);
      o_max_nxt = i_load ? i_d : (i_d > r_max ? i_d : r_max);
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_min <= '0;
         r_max <= '0;
      end else if (i_load || i_upd) begin
         r_min <= o_min_nxt;
         r_max <= o_max_nxt;
      end
   end
endmodule

// File: rtl/tdc_meas_stats.sv
// tdc_meas_stats: windowed mean/min/max over 2^LOG2_N TDC samples, emitted over valid/ready.
// A result not accepted before the next window completes is overwritten and counted in drop_cnt.
module tdc_meas_stats import tdc_pkg::*; #(
   parameter int MEAS_W = TDC_MEAS_W,
   parameter int LOG2_N = TDC_LOG2_N,
   parameter int DROP_W = 16
) (
   input  logic              clk_100m,
   input  logic              rst_n,
   input  logic [MEAS_W-1:0] meas_in,
   input  logic              meas_valid,
   input  logic              clear,
   output logic [MEAS_W-1:0] avg_out,
   output logic [MEAS_W-1:0] min_out,
   output logic [MEAS_W-1:0] max_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LOG2_N-1:0] fill,
   output logic [DROP_W-1:0] drop_cnt
);
   localparam int ACC_W = acc_w(MEAS_W, LOG2_N);
   localparam logic [LOG2_N-1:0] LAST = '1;

   logic [ACC_W-1:0]  r_acc, w_acc_nxt;
   logic [MEAS_W-1:0] w_min_nxt, w_max_nxt;
   logic              w_take, w_first, w_done;

   always_comb begin
      w_take    = meas_valid && !clear;
      w_first   = fill == '0;
      w_done    = w_take && fill == LAST;
      w_acc_nxt = w_first ? ACC_W'(meas_in) : r_acc + ACC_W'(meas_in);
   end

   tdc_minmax_track #(.W(MEAS_W)) u_minmax (
      .clk_100m  (clk_100m),
      .rst_n     (rst_n),
      .i_load    (w_take && w_first),
      .i_upd     (w_take && !w_first),
      .i_d       (meas_in),
      .o_min_nxt (w_min_nxt),
      .o_max_nxt (w_max_nxt)
   );

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         fill      <= '0;
         avg_out   <= '0;
         min_out   <= '0;
         max_out   <= '0;
         out_valid <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         if (clear) begin
            fill <= '0;
         end else if (meas_valid) begin
            fill  <= fill + 1'b1;
            r_acc <= w_acc_nxt;
         end
         // A completion always wins over acceptance; only an unaccepted old result counts as dropped.
         if (w_done) begin
            avg_out   <= w_acc_nxt[ACC_W-1:LOG2_N];
            min_out   <= w_min_nxt;
            max_out   <= w_max_nxt;
            out_valid <= 1'b1;
            if (out_valid && !out_ready && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/tdc_meas_stats.md
Name: tdc_meas_stats

Overview:
Windowed statistics stage between the TDC core and the rate-limited UART measurement buffer. Consumes every 40-bit measurement/meas_valid pulse from the TDC core and accumulates a window of 2^LOG2_N samples. At the end of each window it emits the mean, minimum and maximum over a valid/ready handshake. The rate limiter therefore forwards a noise-reduced statistic instead of one arbitrary raw sample per 50 ms.

Parameters:
MEAS_W, 40, measurement width in bits
LOG2_N, 4, log2 of samples per window; legal range 1..8 (N = 16 by default)
DROP_W, 16, width of the saturating dropped-result counter

Ports:
clk_100m  in  1  system clock, 100 MHz
rst_n  in  1  reset: asynchronous, active-low
meas_in  in  MEAS_W  measurement from TDC core
meas_valid  in  1  single-cycle strobe; meas_in is valid in this cycle
clear  in  1  synchronous discard of the partial window
avg_out  out  MEAS_W  window mean, floor(sum / N)
min_out  out  MEAS_W  window minimum, unsigned
max_out  out  MEAS_W  window maximum, unsigned
out_valid  out  1  result registers hold an unconsumed result
out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready
fill  out  LOG2_N  samples in the current partial window
drop_cnt  out  DROP_W  results overwritten before acceptance; saturates at all-ones

Behaviour:
- Reset: every output, the accumulator and the window state go to 0, asynchronously.
- Accumulator width is MEAS_W+LOG2_N. A full window of all-ones samples cannot overflow.
- Each meas_valid cycle without clear:
  - If fill==0: acc, running min and running max are all loaded with meas_in.
  - Otherwise: acc += meas_in; running min/max are updated with unsigned compares.
  - fill increments and wraps to 0 after N-1.
- Window completion (meas_valid while fill==N-1), same clock edge:
  - avg_out <= (acc+meas_in) >> LOG2_N, truncating.
  - min_out and max_out take the running values including the Nth sample.
  - out_valid <= 1. Latency: the result is visible in the cycle after the Nth meas_valid.
- Handshake:
  - When out_valid && out_ready and no completion occurs that cycle, out_valid <= 0 next cycle.
  - Result outputs are stable while out_valid=1, except when overwritten.
- Overwrite: completion while out_valid=1 && !out_ready. The new result replaces the old one, out_valid stays 1, and drop_cnt increments.
- Completion and acceptance in the same cycle: the old result is transferred, the new one is loaded, out_valid stays 1, and drop_cnt is unchanged.
- clear:
  - fill <= 0. The running acc/min/max are don't-care because they reload on the next sample.
  - A meas_valid in the same cycle as clear is discarded.
  - A pending result and out_valid are unaffected.
  - clear in the completion cycle suppresses that completion.
- Reset asserted mid-window or with a pending result: everything is lost, no result is emitted, and drop_cnt returns to 0.
- meas_in is sampled only when meas_valid=1 and is ignored otherwise.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package tdc_pkg holds:
  - the MEAS_W default (40), shared with tdc_core and the top level;
  - the default LOG2_N;
  - a helper constant for the accumulator width (MEAS_W+LOG2_N).
- One natural sub-module, tdc_minmax_track. It holds the running min/max registers with load/update enables and keeps the compare logic isolated and separately testable.
- The accumulator, fill counter and handshake stay in the parent.

Test Plan:
(All scenarios use LOG2_N=2, so N=4.)
- Basic window: samples 10, 20, 30, 41 with out_ready=0 -> one cycle after the 4th sample, out_valid=1, avg_out=25, min_out=10, max_out=41, fill=0, drop_cnt=0.
- Width boundary: four samples of 2^40-1 -> avg_out=2^40-1, min_out=max_out=2^40-1. Then samples 0, 0, 0, 3 -> avg_out=0, min_out=0, max_out=3.
- Overwrite: out_ready=0 through two windows (1,1,1,1) then (8,8,8,8) -> avg_out=8, out_valid=1, drop_cnt=1. Then pulse out_ready -> out_valid=0 next cycle.
- Simultaneous accept and complete: out_ready=1 exactly in the cycle of the second window's 4th sample -> out_valid stays 1, drop_cnt=0, and the outputs show the second window.
- Clear mid-window: samples 100, 200, then clear, then 1, 2, 3, 6 -> avg_out=3, min_out=1, max_out=6. clear coincident with a sample -> fill unchanged at 0.
- Reset mid-operation: assert rst_n=0 after 2 samples while a result is pending -> all outputs 0 immediately. After release, a full window of 5s -> avg_out=5.
